ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite responder terminating cpu_core's a_* master bus: on-chip word-organised SRAM with byte/halfword/word access.
//  Sits behind the bus decoder (s_hsel), returns OKAY/ERROR, optional wait-state insertion.
//  Single clock domain; no bursts beyond per-beat handling (HBURST accepted, ignored).
// PARAMETERS
//  MEM_DEPTH    256  number of DATA_WIDTH-bit words; address range 0 .. MEM_DEPTH*4-1 (offset from decode base)
//  WAIT_CYCLES  1    wait states per accepted transfer (only with AHB_SLV_WAIT_EN); 0..15
// PORTS
//  clk          in   1             system clock, rising edge
//  rst_n        in   1             asynchronous, active-low reset
//  s_hsel       in   1             slave select from decoder
//  s_haddr      in   `ADDR_WIDTH   transfer address
//  s_htrans     in   2             IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  s_hwrite     in   1             1=write
//  s_hsize      in   3             000 byte, 001 half, 010 word; others illegal
//  s_hburst     in   3             accepted, no effect
//  s_hwdata     in   `DATA_WIDTH   write data (data phase)
//  s_hready_in  in   1             bus HREADY (previous data phase done)
//  s_hreadyout  out  1             this slave's HREADY
//  s_hresp      out  1             0 OKAY, 1 ERROR
//  s_hrdata     out  `DATA_WIDTH   read data (data phase)
// BEHAVIOUR
//  Reset: s_hreadyout=1, s_hresp=0, s_hrdata=0, FSM=IDLE, wait counter=0; SRAM contents undefined (not reset).
//  Accept: address phase captured when s_hsel & s_hready_in & s_htrans[1]; latch addr, write, size.
//  IDLE/BUSY or !s_hsel with s_hready_in: no capture, next cycle zero-wait OKAY.
//  Error check at capture: addr >= MEM_DEPTH*4, hsize>2, or misaligned (half: addr[0]!=0; word: addr[1:0]!=0).
//  FSM states: IDLE, WAIT, ERR1, ERR2.
//   IDLE: hreadyout=1, hresp=0. Legal capture -> WAIT if wait count>0 else stays IDLE (data phase done next cycle).
//         Error capture -> ERR1.
//   WAIT: hreadyout=0, hresp=0; counter decrements; at 1 -> IDLE (data phase completes in IDLE cycle).
//   ERR1: hreadyout=0, hresp=1; -> ERR2 unconditionally.
//   ERR2: hreadyout=1, hresp=1; new address may be captured here (same rules as IDLE).
//  Errored transfers never modify SRAM; error path ignores WAIT_CYCLES.
//  Write: committed at clock edge ending data phase (hreadyout=1); byte enables from size/addr[1:0], little-endian;
//   data taken from matching s_hwdata lanes. Read: s_hrdata = SRAM[word addr] full word, combinational from
//   captured addr, valid when hreadyout=1; otherwise 0. Read immediately after write to same word returns new data.
//  Back-to-back pipelined transfers with zero waits: one transfer per cycle sustained.
//  Reset mid-transfer: FSM to IDLE immediately, pending write discarded.
// CONFIGURATION
//  AHB_SLV_WAIT_EN defined: each legal transfer inserts WAIT_CYCLES wait states (hreadyout low) before completion.
//  Not defined: WAIT state and counter absent; all legal transfers zero-wait, WAIT_CYCLES ignored.
// STRUCTURE
//  Shared defines header: `ADDR_WIDTH, `DATA_WIDTH, HTRANS codes, HSIZE codes, HRESP_OKAY/HRESP_ERROR,
//   FSM state encodings.
//  Sub-module ahb_slv_mem: MEM_DEPTH x DATA_WIDTH array, 4-bit byte-write-enable, async read port.
// TESTING
//  1 Word write 0x0000_0010=0xDEADBEEF, then read -> s_hrdata=0xDEADBEEF, s_hresp=0 both beats.
//  2 Byte write 0xA5 @0x13 over 0x11223344 -> read word 0x10 = 0xA5223344; half write 0xBEEF @0x12 -> 0xBEEF3344.
//  3 Word read @0x2 (misaligned) -> ERR1 (hreadyout=0,hresp=1) then ERR2 (1,1); SRAM unchanged.
//  4 Read @MEM_DEPTH*4 (0x400) -> two-cycle ERROR; following NONSEQ read @0x0 captured in ERR2 returns OKAY.
//  5 AHB_SLV_WAIT_EN, WAIT_CYCLES=2: write @0x20 -> hreadyout low 2 cycles, then high; rdata correct on read back.
//  6 4 pipelined NONSEQ writes then reads, zero-wait, rst_n pulsed mid-write -> hreadyout=1, hresp=0, that word unchanged.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// rtl/ahb_sram_slave_pkg.sv - shared bus widths, AHB codes, FSM encoding and lane helpers
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package ahb_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } slv_state_e;

  // Little-endian byte lanes touched by a transfer of the given size at the given low address bits
  function automatic logic [3:0] f_byte_en(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      HSIZE_BYTE: f_byte_en = 4'b0001 << lsb;
      HSIZE_HALF: f_byte_en = lsb[1] ? 4'b1100 : 4'b0011;
      default:    f_byte_en = 4'b1111;
    endcase
  endfunction

  // Halfwords need an even address, words a multiple of four
  function automatic logic f_misaligned(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      HSIZE_HALF: f_misaligned = lsb[0];
      HSIZE_WORD: f_misaligned = |lsb;
      default:    f_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// rtl/ahb_slv_mem.sv - word-organised SRAM array with byte write enables and async read
module ahb_slv_mem #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic                   clk,
  input  logic [3:0]             i_we,
  input  logic [IDX_W-1:0]       i_idx,
  input  logic [`DATA_WIDTH-1:0] i_wdata,
  output logic [`DATA_WIDTH-1:0] o_rdata
);

  logic [`DATA_WIDTH-1:0] r_mem [DEPTH];

  // Byte-lane writes; contents are deliberately not reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) begin
        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM responder; wait states enabled by AHB_SLV_WAIT_EN
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_hsel,
  input  logic [`ADDR_WIDTH-1:0] s_haddr,
  input  logic [1:0]             s_htrans,
  input  logic                   s_hwrite,
  input  logic [2:0]             s_hsize,
  input  logic [2:0]             s_hburst,
  input  logic [`DATA_WIDTH-1:0] s_hwdata,
  input  logic                   s_hready_in,
  output logic                   s_hreadyout,
  output logic                   s_hresp,
  output logic [`DATA_WIDTH-1:0] s_hrdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [`ADDR_WIDTH-1:0] ADDR_LIMIT = `ADDR_WIDTH'(MEM_DEPTH * 4);

  slv_state_e             r_state;
  logic [IDX_W+1:0]       r_addr;
  logic                   r_write;
  logic [2:0]             r_size;
  logic                   r_dphase;
  logic                   r_hreadyout;
  logic                   r_hresp;
`ifdef AHB_SLV_WAIT_EN
  logic [3:0]             r_wait_cnt;
`endif

  logic                   w_active;
  logic                   w_capture;
  logic                   w_err;
  logic                   w_done;
  logic [3:0]             w_we;
  logic [`DATA_WIDTH-1:0] w_mem_rdata;
  logic                   w_unused;

  // Bursts are handled beat by beat, so HBURST carries no information here
  assign w_unused  = ^s_hburst;
  assign w_active  = (s_htrans != HTRANS_IDLE) && (s_htrans != HTRANS_BUSY);
  assign w_capture = s_hsel & s_hready_in & w_active;
  assign w_err     = (s_haddr >= ADDR_LIMIT) | (s_hsize > HSIZE_WORD)
                   | f_misaligned(s_hsize, s_haddr[1:0]);

  // A pending legal data phase finishes in any cycle where this slave drives HREADY high
  assign w_done = r_dphase & r_hreadyout;
  assign w_we   = (w_done & r_write) ? f_byte_en(r_size, r_addr[1:0]) : 4'b0000;

  // Single FSM: address capture, wait counting, two-cycle error response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_size      <= HSIZE_BYTE;
      r_dphase    <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
`ifdef AHB_SLV_WAIT_EN
      r_wait_cnt  <= 4'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR2: begin
          r_dphase    <= 1'b0;
          r_state     <= ST_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
          if (w_capture) begin
            r_addr  <= s_haddr[IDX_W+1:0];
            r_write <= s_hwrite;
            r_size  <= s_hsize;
            if (w_err) begin
              r_state     <= ST_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_ERROR;
            end else begin
              r_dphase <= 1'b1;
`ifdef AHB_SLV_WAIT_EN
              if (WAIT_CYCLES > 0) begin
                r_state     <= ST_WAIT;
                r_wait_cnt  <= 4'(WAIT_CYCLES);
                r_hreadyout <= 1'b0;
              end
`endif
            end
          end
        end
        ST_WAIT: begin
`ifdef AHB_SLV_WAIT_EN
          r_wait_cnt <= r_wait_cnt - 4'd1;
          if (r_wait_cnt <= 4'd1) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
          end
`else
          r_state     <= ST_IDLE;
          r_hreadyout <= 1'b1;
`endif
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

  ahb_slv_mem #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_idx   (r_addr[IDX_W+1:2]),
    .i_wdata (s_hwdata),
    .o_rdata (w_mem_rdata)
  );

  assign s_hreadyout = r_hreadyout;
  assign s_hresp     = r_hresp;
  assign s_hrdata    = (w_done & ~r_write) ? w_mem_rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - self-checking bench for ahb_sram_slave against a byte-array model
module tb_ahb_sram_slave;

  localparam int MEM_DEPTH = 256;
  localparam int WAIT_CFG  = 2;
`ifdef AHB_SLV_WAIT_EN
  localparam int WAIT_EXP  = WAIT_CFG;
`else
  localparam int WAIT_EXP  = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_hsel;
  logic [31:0] s_haddr;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [2:0]  s_hburst;
  logic [31:0] s_hwdata;
  logic        s_hreadyout;
  logic        s_hresp;
  logic [31:0] s_hrdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  model_b [0:MEM_DEPTH*4-1];
  logic [31:0] op_addr [0:511];
  logic        op_w    [0:511];
  logic [2:0]  op_sz   [0:511];
  logic [31:0] op_wd   [0:511];
  int          n_ops = 0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  ahb_sram_slave #(
    .MEM_DEPTH   (MEM_DEPTH),
    .WAIT_CYCLES (WAIT_CFG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_hsel      (s_hsel),
    .s_haddr     (s_haddr),
    .s_htrans    (s_htrans),
    .s_hwrite    (s_hwrite),
    .s_hsize     (s_hsize),
    .s_hburst    (s_hburst),
    .s_hwdata    (s_hwdata),
    .s_hready_in (s_hreadyout),
    .s_hreadyout (s_hreadyout),
    .s_hresp     (s_hresp),
    .s_hrdata    (s_hrdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int base;
    base = int'(a) & ~3;
    return {model_b[base+3], model_b[base+2], model_b[base+1], model_b[base]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) begin
      int b;
      b = int'(a) + i;
      model_b[b] = wd[8*(b%4) +: 8];
    end
  endtask

  task automatic bus_idle();
    s_hsel   = 1'b0;
    s_htrans = 2'b00;
    s_hwrite = 1'b0;
    s_hsize  = 3'b010;
    s_haddr  = 32'h0;
  endtask

  task automatic add_op(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd);
    op_addr[n_ops] = a;
    op_w[n_ops]    = w;
    op_sz[n_ops]   = sz;
    op_wd[n_ops]   = wd;
    n_ops++;
  endtask

  // Issues the queued ops back to back, honouring HREADY; checks every completed data phase
  task automatic run_pipe();
    int issue = 0;
    int dp    = -1;
    int waits = 0;
    int cyc   = 0;
    int n;
    logic rdy;
    n = n_ops;
    while ((issue < n || dp >= 0) && cyc < 4000) begin
      if (issue < n) begin
        s_hsel   = 1'b1;
        s_htrans = 2'b10;
        s_haddr  = op_addr[issue];
        s_hwrite = op_w[issue];
        s_hsize  = op_sz[issue];
        s_hburst = 3'($urandom);
      end else begin
        bus_idle();
      end
      s_hwdata = (dp >= 0 && op_w[dp]) ? op_wd[dp] : $urandom;
      rdy = s_hreadyout;
      if (dp >= 0) begin
        if (!rdy) begin
          waits++;
        end else begin
          chk("pipe_resp", 32'(s_hresp), 32'h0);
          if (op_w[dp]) begin
            model_write(op_addr[dp], op_sz[dp], op_wd[dp]);
          end else begin
            last_rd = s_hrdata;
            chk("pipe_rdata", s_hrdata, model_word(op_addr[dp]));
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        dp = (issue < n) ? issue : -1;
        if (issue < n) issue++;
      end
    end
    bus_idle();
    chk("pipe_done", 32'(issue >= n && dp < 0), 32'h1);
    chk("pipe_waits", 32'(waits), 32'(n * WAIT_EXP));
    n_ops = 0;
  endtask

  // Illegal transfer: expects ERROR with HREADY low then high; returns in the second error cycle
  task automatic err_xfer(input string tag, input logic [31:0] a, input logic [2:0] sz, input logic w);
    s_hsel   = 1'b1;
    s_htrans = 2'b10;
    s_haddr  = a;
    s_hsize  = sz;
    s_hwrite = w;
    @(posedge clk); #1;
    bus_idle();
    s_hwdata = 32'hFFFF_FFFF;
    chk({tag, "_err1_ready"}, 32'(s_hreadyout), 32'h0);
    chk({tag, "_err1_resp"},  32'(s_hresp),     32'h1);
    @(posedge clk); #1;
    chk({tag, "_err2_ready"}, 32'(s_hreadyout), 32'h1);
    chk({tag, "_err2_resp"},  32'(s_hresp),     32'h1);
  endtask

  initial begin
    rst_n    = 1'b0;
    s_hburst = 3'b000;
    s_hwdata = 32'h0;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(s_hreadyout), 32'h1);
    chk("rst_resp",  32'(s_hresp),     32'h0);
    chk("rst_rdata", s_hrdata,         32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < MEM_DEPTH; i++) add_op(32'(i * 4), 1'b1, 3'b010, $urandom);
    run_pipe();

    add_op(32'h10, 1'b1, 3'b010, 32'hDEAD_BEEF);
    add_op(32'h10, 1'b0, 3'b010, 32'h0);
    run_pipe();
    chk("t1_word_rd", last_rd, 32'hDEAD_BEEF);

    add_op(32'h10, 1'b1, 3'b010, 32'h1122_3344);
    add_op(32'h13, 1'b1, 3'b000, 32'hA5A5_A5A5);
    add_op(32'h10, 1'b0, 3'b010, 32'h0);
    run_pipe();
    chk("t2_byte_rd", last_rd, 32'hA522_3344);
    add_op(32'h12, 1'b1, 3'b001, 32'hBEEF_0000);
    add_op(32'h10, 1'b0, 3'b010, 32'h0);
    run_pipe();
    chk("t2_half_rd", last_rd, 32'hBEEF_3344);

    err_xfer("t3_misalign_word", 32'h2,  3'b010, 1'b0);
    err_xfer("t3_misalign_half", 32'h11, 3'b001, 1'b1);
    err_xfer("t3_bad_size",      32'h10, 3'b011, 1'b1);
    err_xfer("t4_out_of_range",  32'(MEM_DEPTH * 4), 3'b010, 1'b0);
    add_op(32'h0, 1'b0, 3'b010, 32'h0);
    run_pipe();
    add_op(32'h10, 1'b0, 3'b010, 32'h0);
    run_pipe();
    chk("t3_sram_unchanged", last_rd, 32'hBEEF_3344);

    s_hsel   = 1'b0;
    s_htrans = 2'b10;
    s_hwrite = 1'b1;
    s_hsize  = 3'b010;
    s_haddr  = 32'h10;
    @(posedge clk); #1;
    s_hsel   = 1'b1;
    s_htrans = 2'b01;
    s_hwdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    bus_idle();
    chk("nosel_ready", 32'(s_hreadyout), 32'h1);
    chk("nosel_resp",  32'(s_hresp),     32'h0);
    @(posedge clk); #1;
    add_op(32'h10, 1'b0, 3'b010, 32'h0);
    run_pipe();
    chk("nosel_unchanged", last_rd, 32'hBEEF_3344);

    add_op(32'h20, 1'b1, 3'b010, 32'hCAFE_F00D);
    add_op(32'h20, 1'b0, 3'b010, 32'h0);
    run_pipe();
    chk("t5_rd", last_rd, 32'hCAFE_F00D);

    for (int i = 0; i < 4; i++) add_op(32'h40 + 32'(i * 4), 1'b1, 3'b010, $urandom);
    for (int i = 0; i < 4; i++) add_op(32'h40 + 32'(i * 4), 1'b0, 3'b010, 32'h0);
    run_pipe();

    s_hsel   = 1'b1;
    s_htrans = 2'b10;
    s_hwrite = 1'b1;
    s_hsize  = 3'b010;
    s_haddr  = 32'h44;
    @(posedge clk); #1;
    bus_idle();
    s_hwdata = 32'h5555_AAAA;
    rst_n    = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(s_hreadyout), 32'h1);
    chk("t6_rst_resp",  32'(s_hresp),     32'h0);
    chk("t6_rst_rdata", s_hrdata,         32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    add_op(32'h44, 1'b0, 3'b010, 32'h0);
    run_pipe();

    for (int i = 0; i < 300; i++) begin
      logic [2:0]  sz;
      logic [31:0] a;
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, MEM_DEPTH * 4 - 1)) & ~((32'h1 << sz) - 32'h1);
      add_op(a, 1'($urandom_range(0, 1)), sz, $urandom);
    end
    run_pipe();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
